layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 27 ++
 rtl/layer_sequencer_argmax_seq.sv | 57 +++++
 rtl/layer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the inference sequencer and its argmax scanner.
package nn_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned PROB_W      = 16;
  localparam int unsigned CLASS_W     = 4;
  localparam int unsigned SM_BUS_W    = NUM_CLASSES * PROB_W;

  typedef logic [PROB_W-1:0] prob_t;

  // Softmax result vector; class k occupies bits [16k+15:16k].
  typedef logic [NUM_CLASSES-1:0][PROB_W-1:0] prob_vec_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RUN1   = 4'd1,
    ST_WAIT1  = 4'd2,
    ST_RUN2   = 4'd3,
    ST_WAIT2  = 4'd4,
    ST_RUN3   = 4'd5,
    ST_WAIT3  = 4'd6,
    ST_WAITSM = 4'd7,
    ST_ARGMAX = 4'd8,
    ST_FIN    = 4'd9
  } seq_state_e;

endpackage

// File: rtl/layer_sequencer_argmax_seq.sv
// Sequential argmax over the softmax vector: one class per cycle, unsigned,
// strictly-greater replacement so ties keep the lowest index.
module argmax_seq
  import nn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  prob_vec_t          bus,
  output logic               done,
  output logic [CLASS_W-1:0] index
);

  localparam int unsigned LAST_CLASS = NUM_CLASSES - 1;

  prob_vec_t          bus_q;
  logic [CLASS_W-1:0] cls_q;
  prob_t              best_q;
  logic               active_q;
  prob_t              cand_c;

  assign cand_c = bus_q[cls_q];

  // Load snapshot, then walk classes 0..9 keeping the running best.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q    <= '0;
      cls_q    <= '0;
      best_q   <= '0;
      index    <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        bus_q    <= bus;
        cls_q    <= '0;
        best_q   <= '0;
        index    <= '0;
        active_q <= 1'b1;
      end else if (active_q) begin
        if (cand_c > best_q) begin
          best_q <= cand_c;
          index  <= cls_q;
        end
        if (cls_q == CLASS_W'(LAST_CLASS)) begin
          cls_q    <= '0;
          active_q <= 1'b0;
          done     <= 1'b1;
        end else begin
          cls_q <= cls_q + CLASS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Drives one inference through three layers, waits for softmax and reports
// the argmax class. Optional wait-state watchdog: define SEQ_WATCHDOG_EN.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned L1_N        = 784,
  parameter int unsigned L2_N        = 128,
  parameter int unsigned L3_N        = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                l1_done,
  input  logic                l2_done,
  input  logic                l3_done,
  input  logic                sm_valid,
  input  logic [SM_BUS_W-1:0] sm_bus,
  output logic [ADDR_W-1:0]   addr,
  output logic                l1_run,
  output logic                l2_run,
  output logic                l3_run,
  output logic                busy,
  output logic                done,
  output logic [CLASS_W-1:0]  prediction,
  output logic                err
);

  // Reject configurations the address counter or watchdog cannot represent.
  if (((64'd1 << ADDR_W) < 64'(L1_N)) || ((64'd1 << ADDR_W) < 64'(L2_N)) ||
      ((64'd1 << ADDR_W) < 64'(L3_N)) || (TIMEOUT_CYC < 2)) begin : g_bad_config
    $error("layer_sequencer: ADDR_W too narrow for a layer size, or TIMEOUT_CYC < 2");
  end

  seq_state_e         state_q, state_c;
  prob_vec_t          sm_q, sm_n;
  logic               amx_load_q, amx_load_n;
  logic               amx_done;
  logic [CLASS_W-1:0] amx_index;

  logic [ADDR_W-1:0]  addr_n;
  logic               l1_run_n, l2_run_n, l3_run_n;
  logic               busy_n, done_n;
  logic [CLASS_W-1:0] pred_n;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_n;
  logic            wd_fire_c;
  logic            err_n;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sm_q       <= '0;
      amx_load_q <= 1'b0;
      addr       <= '0;
      l1_run     <= 1'b0;
      l2_run     <= 1'b0;
      l3_run     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      prediction <= '0;
`ifdef SEQ_WATCHDOG_EN
      wd_q       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      state_q    <= state_c;
      sm_q       <= sm_n;
      amx_load_q <= amx_load_n;
      addr       <= addr_n;
      l1_run     <= l1_run_n;
      l2_run     <= l2_run_n;
      l3_run     <= l3_run_n;
      busy       <= busy_n;
      done       <= done_n;
      prediction <= pred_n;
`ifdef SEQ_WATCHDOG_EN
      wd_q       <= wd_n;
      err        <= err_n;
`endif
    end
  end

  // Next-state: layer handshakes are honoured only in their own wait state.
  always_comb begin
    state_c = state_q;
`ifdef SEQ_WATCHDOG_EN
    wd_fire_c = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE:   if (start)                          state_c = ST_RUN1;
      ST_RUN1:   if (addr == ADDR_W'(L1_N - 1))      state_c = ST_WAIT1;
      ST_WAIT1:  if (l1_done)                        state_c = ST_RUN2;
      ST_RUN2:   if (addr == ADDR_W'(L2_N - 1))      state_c = ST_WAIT2;
      ST_WAIT2:  if (l2_done)                        state_c = ST_RUN3;
      ST_RUN3:   if (addr == ADDR_W'(L3_N - 1))      state_c = ST_WAIT3;
      ST_WAIT3:  if (l3_done)                        state_c = ST_WAITSM;
      ST_WAITSM: if (sm_valid)                       state_c = ST_ARGMAX;
      ST_ARGMAX: if (amx_done)                       state_c = ST_FIN;
      ST_FIN:                                        state_c = ST_IDLE;
      default:                                       state_c = ST_IDLE;
    endcase
`ifdef SEQ_WATCHDOG_EN
    // A handshake arriving on the last allowed cycle still wins over the timeout.
    if ((state_q inside {ST_WAIT1, ST_WAIT2, ST_WAIT3, ST_WAITSM}) &&
        (state_c == state_q) && (wd_q == WD_W'(TIMEOUT_CYC - 1))) begin
      wd_fire_c = 1'b1;
      state_c   = ST_IDLE;
    end
`endif
  end

  // Output and datapath next values, aligned with the next state.
  always_comb begin
    addr_n     = '0;
    l1_run_n   = (state_c == ST_RUN1);
    l2_run_n   = (state_c == ST_RUN2);
    l3_run_n   = (state_c == ST_RUN3);
    busy_n     = (state_c != ST_IDLE);
    done_n     = (state_c == ST_FIN);
    pred_n     = prediction;
    sm_n       = sm_q;
    amx_load_n = 1'b0;

    if ((state_c == state_q) && (state_q inside {ST_RUN1, ST_RUN2, ST_RUN3})) begin
      addr_n = addr + ADDR_W'(1);
    end
    if ((state_q == ST_WAITSM) && sm_valid) begin
      sm_n       = prob_vec_t'(sm_bus);
      amx_load_n = 1'b1;
    end
    if ((state_q == ST_ARGMAX) && amx_done) begin
      pred_n = amx_index;
    end

`ifdef SEQ_WATCHDOG_EN
    wd_n  = '0;
    err_n = err;
    if ((state_c == state_q) && (state_q inside {ST_WAIT1, ST_WAIT2, ST_WAIT3, ST_WAITSM})) begin
      wd_n = wd_q + WD_W'(1);
    end
    if ((state_q == ST_IDLE) && start) begin
      err_n = 1'b0;
    end
    if (wd_fire_c) begin
      err_n = 1'b1;
    end
`endif
  end

`ifndef SEQ_WATCHDOG_EN
  assign err = 1'b0;
`endif

  argmax_seq u_argmax (
    .clk   (clk),
    .rst   (rst),
    .load  (amx_load_q),
    .bus   (sm_q),
    .done  (amx_done),
    .index (amx_index)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a responder models the layers and
// softmax, the test pushes expected (class, done cycle) pairs, a monitor checks.
`timescale 1ns/1ps
module tb_layer_sequencer;
  import nn_pkg::*;

  localparam int unsigned L1 = 784;
  localparam int unsigned L2 = 128;
  localparam int unsigned L3 = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned TO = 64;
  // Start-to-done: layer inputs + 13 fixed + waits of 3+3+3 (layers) + 2 (softmax).
  localparam int LAT = L1 + L2 + L3 + 13 + 11;

  logic            clk = 1'b0;
  logic            rst, start, l1_done, l2_done, l3_done, sm_valid;
  prob_vec_t       sm_bus;
  logic [AW-1:0]   addr;
  logic            l1_run, l2_run, l3_run, busy, done, err;
  logic [3:0]      prediction;

  layer_sequencer #(
    .L1_N(L1), .L2_N(L2), .L3_N(L3), .ADDR_W(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
    .sm_valid(sm_valid), .sm_bus(sm_bus),
    .addr(addr), .l1_run(l1_run), .l2_run(l2_run), .l3_run(l3_run),
    .busy(busy), .done(done), .prediction(prediction), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] pred; int cycle; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int r1 = 0, r2 = 0, r3 = 0;
  int run_idx = 0;
  bit hang_l2 = 1'b0;
  int stray_cyc = -1;
  int cd1 = 0, cd2 = 0, cd3 = 0, cds = 0;
  bit p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  task automatic set_bus(input logic [15:0] dflt, input int k1, input logic [15:0] v1,
                         input int k2, input logic [15:0] v2);
    for (int i = 0; i < 10; i++) sm_bus[i] = dflt;
    if (k1 >= 0) sm_bus[k1] = v1;
    if (k2 >= 0) sm_bus[k2] = v2;
  endtask

  // Pulse start for one cycle; optionally expect a done with the given class.
  task automatic launch(input bit expect_done, input logic [3:0] pred, output int s);
    exp_t e;
    s = cyc;
    r1 = 0; r2 = 0; r3 = 0;
    if (expect_done) begin
      e.pred  = pred;
      e.cycle = s + LAT;
      exp_q.push_back(e);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      tick(1);
      n++;
    end
    check("done_arrived", 32'(done_cnt >= target), 32'd1);
  endtask

  // Layer/softmax responder: done 3 cycles after the last addr, sm_valid 2 after l3_done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0; sm_valid = 1'b0;
      if (cds > 0) begin cds--; if (cds == 0) sm_valid = 1'b1; end
      if (cd1 > 0) begin cd1--; if (cd1 == 0) l1_done = 1'b1; end
      if (cd2 > 0) begin cd2--; if (cd2 == 0 && !hang_l2) l2_done = 1'b1; end
      if (cd3 > 0) begin cd3--; if (cd3 == 0) begin l3_done = 1'b1; cds = 2; end end
      if (p1 && !l1_run) cd1 = 2;
      if (p2 && !l2_run) cd2 = 2;
      if (p3 && !l3_run) cd3 = 2;
      p1 = l1_run; p2 = l2_run; p3 = l3_run;
      if (cyc == stray_cyc) begin
        l1_done = 1'b1; l2_done = 1'b1; l3_done = 1'b1; sm_valid = 1'b1;
      end
    end
  end

  // Monitor: run exclusivity, address walk, run lengths and the done scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("run_onehot", 32'((int'(l1_run) + int'(l2_run) + int'(l3_run)) <= 1), 32'd1);
      if (l1_run || l2_run || l3_run) begin
        check("addr_walk", 32'(addr), 32'(run_idx));
        run_idx++;
      end else begin
        check("addr_idle", 32'(addr), 32'd0);
        run_idx = 0;
      end
      if (l1_run) r1++;
      if (l2_run) r2++;
      if (l3_run) r3++;
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check("prediction", 32'(prediction), 32'(e.pred));
          check("done_cycle", 32'(cyc), 32'(e.cycle));
        end
      end
    end
  end

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; sm_bus = '0;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0; sm_valid = 1'b0;
    tick(3);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_runs", 32'({l1_run, l2_run, l3_run}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pred", 32'(prediction), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(2);

    // Nominal: class 7 dominates.
    set_bus(16'h0100, 7, 16'h9000, -1, 16'h0);
    launch(1'b1, 4'd7, s);
    check("busy_running", 32'(busy), 32'd1);
    wait_done(1, 1200);
    check("l1_run_len", 32'(r1), 32'(L1));
    check("l2_run_len", 32'(r2), 32'(L2));
    check("l3_run_len", 32'(r3), 32'(L3));
    tick(2);
    check("busy_after", 32'(busy), 32'd0);

    // Tie on classes 2 and 5, with stray handshakes and a start while busy.
    set_bus(16'h1234, 2, 16'hFFFF, 5, 16'hFFFF);
    launch(1'b1, 4'd2, s);
    stray_cyc = s + 50;
    tick_to(s + 100);
    check("pred_held", 32'(prediction), 32'd7);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(2, 1200);
    tick(3);

    // Unsigned compare: 0x8000 at class 9 beats 0x7FFF at class 0.
    set_bus(16'h0001, 0, 16'h7FFF, 9, 16'h8000);
    launch(1'b1, 4'd9, s);
    wait_done(3, 1200);
    tick(3);

    // Abort during RUN1, then a clean run.
    set_bus(16'h0010, 4, 16'h0400, -1, 16'h0);
    launch(1'b0, 4'd0, s);
    tick_to(s + 500);
    check("pre_abort_run", 32'(l1_run), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_runs", 32'({l1_run, l2_run, l3_run}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pred", 32'(prediction), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    tick(5);
    launch(1'b1, 4'd4, s);
    wait_done(4, 1200);
    tick(3);

    // All-zero probabilities resolve to class 0.
    set_bus(16'h0000, -1, 16'h0, -1, 16'h0);
    launch(1'b1, 4'd0, s);
    wait_done(5, 1200);
    tick(3);

    // Layer 2 never answers.
    hang_l2 = 1'b1;
    set_bus(16'h0002, 3, 16'h0300, -1, 16'h0);
    launch(1'b0, 4'd0, s);
`ifdef SEQ_WATCHDOG_EN
    // WAIT2 is entered at s+916; timeout lands TO cycles later.
    tick_to(s + 916 + TO - 1);
    check("wd_err_before", 32'(err), 32'd0);
    check("wd_busy_before", 32'(busy), 32'd1);
    tick(1);
    check("wd_err", 32'(err), 32'd1);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_no_done", 32'(done), 32'd0);
    hang_l2 = 1'b0;
    tick(30);
    check("wd_err_sticky", 32'(err), 32'd1);
    launch(1'b1, 4'd3, s);
    check("wd_err_cleared", 32'(err), 32'd0);
    wait_done(6, 1200);
`else
    tick_to(s + 1200);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_err", 32'(err), 32'd0);
    check("hang_runs", 32'({l1_run, l2_run, l3_run}), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hang_l2 = 1'b0;
    check("hang_rst_busy", 32'(busy), 32'd0);
`endif
    tick(10);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
